// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch sequencer plus DEPTH-entry instruction/PC queue between I-cache and decode.
// Optional perf counters (miss_cycles, flush_drops) are built when IFQ_PERF_CNT_EN is defined.
module if_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          PTR_W    = 2,
   parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [29:0] if_pc,
   input  logic [31:0] insn,
   input  logic        data_rdy,
   input  logic        if_busy,
   input  logic        id_stall,
   input  logic        flush,
   input  logic [29:0] new_pc,
   output logic [31:0] if_insn,
   output logic [29:0] if_insn_pc,
   output logic        if_en,
   output logic        q_full
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0] miss_cycles,
   output logic [15:0] flush_drops
`endif
);
   typedef enum logic [1:0] {FETCH, MISS, REDIR} state_t;

   state_t             state_q, state_d;
   logic [29:0]        if_pc_q, if_pc_d;
   logic [29:0]        redir_pc_q, redir_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [61:0]        mem_q [DEPTH];
   logic [61:0]        mem_d [DEPTH];
   logic [61:0]        head;
   logic               push, pop;

   assign head       = mem_q[rd_ptr_q];
   assign if_en      = count_q != '0;
   assign q_full     = count_q == (PTR_W+1)'(DEPTH);
   assign if_insn    = if_en ? head[61:30] : '0;
   assign if_insn_pc = if_en ? head[29:0] : '0;
   assign if_pc      = if_pc_q;
   assign pop        = if_en & ~id_stall & ~flush;
   assign push       = (state_q == FETCH) & data_rdy & ~if_busy & ~flush & (~q_full | pop);

   always_comb begin
      state_d    = state_q;
      if_pc_d    = push ? if_pc_q + 30'd1 : if_pc_q;
      redir_pc_d = redir_pc_q;
      case (state_q)
         FETCH:
            if (flush & ~if_busy) if_pc_d = new_pc;
            else if (flush) begin
               redir_pc_d = new_pc;
               state_d    = REDIR;
            end else if (if_busy) state_d = MISS;
         MISS:
            if (flush) begin
               redir_pc_d = new_pc;
               state_d    = REDIR;
            end else if (~if_busy) state_d = FETCH;
         REDIR: begin
            // address stays frozen until the refill completes; newest redirect wins
            if (flush) redir_pc_d = new_pc;
            if (~if_busy) begin
               if_pc_d = flush ? new_pc : redir_pc_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
      count_d  = flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {insn, if_pc_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         if_pc_q    <= RESET_PC;
         redir_pc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         if_pc_q    <= if_pc_d;
         redir_pc_q <= redir_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // storage needs no reset: head outputs are masked while empty
   always_ff @(posedge clk) mem_q <= mem_d;

`ifdef IFQ_PERF_CNT_EN
   logic [31:0] miss_cycles_q, miss_cycles_d;
   logic [15:0] flush_drops_q, flush_drops_d;
   logic [16:0] fd_sum;

   always_comb begin
      fd_sum        = {1'b0, flush_drops_q} + 17'(count_q);
      miss_cycles_d = (if_busy && miss_cycles_q != '1) ? miss_cycles_q + 32'd1 : miss_cycles_q;
      flush_drops_d = !flush ? flush_drops_q : fd_sum[16] ? 16'hFFFF : fd_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_cycles_q <= '0;
         flush_drops_q <= '0;
      end else begin
         miss_cycles_q <= miss_cycles_d;
         flush_drops_q <= flush_drops_d;
      end
   end

   assign miss_cycles = miss_cycles_q;
   assign flush_drops = flush_drops_q;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed self-checking bench; a second instance covers the PC wrap at the top of the address space.
module tb_if_fetch_queue;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] insn = '0;
   logic        data_rdy = 1'b0, if_busy = 1'b0, id_stall = 1'b0, flush = 1'b0;
   logic [29:0] new_pc = '0;
   logic [29:0] if_pc, if_insn_pc, w_if_pc, w_if_insn_pc;
   logic [31:0] if_insn, w_if_insn;
   logic        if_en, q_full, w_if_en, w_q_full;
   int          pass = 0, total = 0;
`ifdef IFQ_PERF_CNT_EN
   logic [31:0] miss_cycles, w_miss_cycles;
   logic [15:0] flush_drops, w_flush_drops;
`endif

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .insn(insn), .data_rdy(data_rdy), .if_busy(if_busy),
      .id_stall(id_stall), .flush(flush), .new_pc(new_pc), .if_insn(if_insn),
      .if_insn_pc(if_insn_pc), .if_en(if_en), .q_full(q_full)
`ifdef IFQ_PERF_CNT_EN
      , .miss_cycles(miss_cycles), .flush_drops(flush_drops)
`endif
   );

   if_fetch_queue #(.RESET_PC(30'h3FFF_FFFE)) dut_w (
      .clk(clk), .rst(rst), .if_pc(w_if_pc), .insn(insn), .data_rdy(data_rdy), .if_busy(if_busy),
      .id_stall(id_stall), .flush(flush), .new_pc(new_pc), .if_insn(w_if_insn),
      .if_insn_pc(w_if_insn_pc), .if_en(w_if_en), .q_full(w_q_full)
`ifdef IFQ_PERF_CNT_EN
      , .miss_cycles(w_miss_cycles), .flush_drops(w_flush_drops)
`endif
   );

   function automatic logic [31:0] tag(input logic [29:0] p);
      return {2'b10, p};
   endfunction

   task automatic do_reset;
      rst = 1'b1; data_rdy = 0; if_busy = 0; id_stall = 0; flush = 0; new_pc = '0; insn = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      total++; if (if_pc !== 30'h0) $display("FAIL reset_pc got %h exp 0", if_pc); else pass++;
      total++; if (if_en !== 1'b0) $display("FAIL reset_en got %b exp 0", if_en); else pass++;
      total++; if (q_full !== 1'b0) $display("FAIL reset_full got %b exp 0", q_full); else pass++;
      total++; if (if_insn !== 32'h0) $display("FAIL reset_insn got %h exp 0", if_insn); else pass++;
      total++; if (if_insn_pc !== 30'h0) $display("FAIL reset_insn_pc got %h exp 0", if_insn_pc); else pass++;
      total++; if (w_if_pc !== 30'h3FFF_FFFE) $display("FAIL reset_w_pc got %h exp 3ffffffe", w_if_pc); else pass++;
      rst = 1'b0;
   endtask

   task automatic test_stream;
      do_reset;
      data_rdy = 1;
      for (int k = 0; k < 5; k++) begin
         insn = tag(30'(k));
         total++; if (if_pc !== 30'(k)) $display("FAIL stream_pc[%0d] got %h exp %h", k, if_pc, 30'(k)); else pass++;
         total++; if (q_full !== 1'b0) $display("FAIL stream_full[%0d] got %b exp 0", k, q_full); else pass++;
         if (k > 0) begin
            total++; if (if_en !== 1'b1) $display("FAIL stream_en[%0d] got %b exp 1", k, if_en); else pass++;
            total++; if (if_insn_pc !== 30'(k-1)) $display("FAIL stream_head_pc[%0d] got %h exp %h", k, if_insn_pc, 30'(k-1)); else pass++;
            total++; if (if_insn !== tag(30'(k-1))) $display("FAIL stream_head_insn[%0d] got %h exp %h", k, if_insn, tag(30'(k-1))); else pass++;
         end
         @(negedge clk);
      end
      data_rdy = 0;
   endtask

   task automatic test_stall;
      do_reset;
      data_rdy = 1; id_stall = 1;
      for (int j = 0; j < 7; j++) begin
         insn = tag(30'(j));
         total++; if (if_pc !== 30'(j < 4 ? j : 4)) $display("FAIL stall_pc[%0d] got %h exp %h", j, if_pc, 30'(j < 4 ? j : 4)); else pass++;
         total++; if (q_full !== (j >= 4)) $display("FAIL stall_full[%0d] got %b exp %b", j, q_full, j >= 4); else pass++;
         total++; if (if_en !== (j >= 1)) $display("FAIL stall_en[%0d] got %b exp %b", j, if_en, j >= 1); else pass++;
         @(negedge clk);
      end
      id_stall = 0;
      for (int r = 0; r < 4; r++) begin
         insn = tag(30'(4 + r));
         total++; if (if_insn_pc !== 30'(r)) $display("FAIL drain_head_pc[%0d] got %h exp %h", r, if_insn_pc, 30'(r)); else pass++;
         total++; if (if_insn !== tag(30'(r))) $display("FAIL drain_head_insn[%0d] got %h exp %h", r, if_insn, tag(30'(r))); else pass++;
         total++; if (if_pc !== 30'(4 + r)) $display("FAIL drain_pc[%0d] got %h exp %h", r, if_pc, 30'(4 + r)); else pass++;
         total++; if (q_full !== 1'b1) $display("FAIL drain_full[%0d] got %b exp 1", r, q_full); else pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_miss;
      data_rdy = 1; if_busy = 1; id_stall = 0; insn = 32'hDEAD_BEEF;
      for (int m = 0; m < 11; m++) begin
         total++; if (if_pc !== 30'd8) $display("FAIL miss_pc[%0d] got %h exp 8", m, if_pc); else pass++;
         total++; if (if_en !== (m < 4)) $display("FAIL miss_en[%0d] got %b exp %b", m, if_en, m < 4); else pass++;
         if (m < 4) begin
            total++; if (if_insn_pc !== 30'(4 + m)) $display("FAIL miss_head_pc[%0d] got %h exp %h", m, if_insn_pc, 30'(4 + m)); else pass++;
         end
         @(negedge clk);
      end
      if_busy = 0;
      @(negedge clk);
      total++; if (if_en !== 1'b0) $display("FAIL miss_release_en got %b exp 0", if_en); else pass++;
      total++; if (if_pc !== 30'd8) $display("FAIL miss_release_pc got %h exp 8", if_pc); else pass++;
      insn = tag(30'd8); id_stall = 1;
      @(negedge clk);
      data_rdy = 0;
      total++; if (if_en !== 1'b1) $display("FAIL refill_en got %b exp 1", if_en); else pass++;
      total++; if (if_insn_pc !== 30'd8) $display("FAIL refill_head_pc got %h exp 8", if_insn_pc); else pass++;
      total++; if (if_insn !== tag(30'd8)) $display("FAIL refill_head_insn got %h exp %h", if_insn, tag(30'd8)); else pass++;
      total++; if (if_pc !== 30'd9) $display("FAIL refill_pc got %h exp 9", if_pc); else pass++;
      id_stall = 0;
   endtask

   task automatic test_flush;
      do_reset;
      data_rdy = 1; id_stall = 1;
      for (int j = 0; j < 3; j++) begin
         insn = tag(30'(j));
         @(negedge clk);
      end
      total++; if (if_pc !== 30'd3) $display("FAIL preflush_pc got %h exp 3", if_pc); else pass++;
      total++; if (q_full !== 1'b0) $display("FAIL preflush_full got %b exp 0", q_full); else pass++;
      total++; if (if_insn_pc !== 30'd0) $display("FAIL preflush_head_pc got %h exp 0", if_insn_pc); else pass++;
      flush = 1; new_pc = 30'h100; id_stall = 0; insn = tag(30'd3);
      @(negedge clk);
      flush = 0; id_stall = 1; insn = tag(30'h100);
      total++; if (if_en !== 1'b0) $display("FAIL flush_en got %b exp 0", if_en); else pass++;
      total++; if (if_insn !== 32'h0) $display("FAIL flush_insn got %h exp 0", if_insn); else pass++;
      total++; if (if_pc !== 30'h100) $display("FAIL flush_pc got %h exp 100", if_pc); else pass++;
      @(negedge clk);
      data_rdy = 0;
      total++; if (if_insn_pc !== 30'h100) $display("FAIL postflush_head_pc got %h exp 100", if_insn_pc); else pass++;
      total++; if (if_pc !== 30'h101) $display("FAIL postflush_pc got %h exp 101", if_pc); else pass++;
      id_stall = 0;
   endtask

   task automatic test_redirect;
      do_reset;
      data_rdy = 1; insn = tag(30'd0);
      @(negedge clk);
      insn = tag(30'd1);
      @(negedge clk);
      data_rdy = 0; if_busy = 1; flush = 1; new_pc = 30'h40;
      @(negedge clk);
      flush = 0;
      total++; if (if_pc !== 30'd2) $display("FAIL redir_hold0 got %h exp 2", if_pc); else pass++;
      total++; if (if_en !== 1'b0) $display("FAIL redir_en0 got %b exp 0", if_en); else pass++;
      @(negedge clk);
      flush = 1; new_pc = 30'h80;
      @(negedge clk);
      flush = 0; data_rdy = 1; insn = 32'hDEAD_BEEF;
      total++; if (if_pc !== 30'd2) $display("FAIL redir_hold1 got %h exp 2", if_pc); else pass++;
      @(negedge clk);
      total++; if (if_pc !== 30'd2) $display("FAIL redir_hold2 got %h exp 2", if_pc); else pass++;
      total++; if (if_en !== 1'b0) $display("FAIL redir_busy_hit_en got %b exp 0", if_en); else pass++;
      if_busy = 0;
      @(negedge clk);
      total++; if (if_pc !== 30'h80) $display("FAIL redir_target got %h exp 80", if_pc); else pass++;
      total++; if (if_en !== 1'b0) $display("FAIL redir_stale_en got %b exp 0", if_en); else pass++;
      insn = tag(30'h80); id_stall = 1;
      @(negedge clk);
      data_rdy = 0;
      total++; if (if_insn_pc !== 30'h80) $display("FAIL redir_head_pc got %h exp 80", if_insn_pc); else pass++;
      total++; if (if_insn !== tag(30'h80)) $display("FAIL redir_head_insn got %h exp %h", if_insn, tag(30'h80)); else pass++;
      total++; if (if_pc !== 30'h81) $display("FAIL redir_next_pc got %h exp 81", if_pc); else pass++;
      id_stall = 0;
   endtask

   task automatic test_async_reset;
      do_reset;
      data_rdy = 1;
      for (int j = 0; j < 3; j++) begin
         insn = tag(30'(j));
         @(negedge clk);
      end
      data_rdy = 0; if_busy = 1;
      @(negedge clk);
      total++; if (if_pc !== 30'd3) $display("FAIL premiss_pc got %h exp 3", if_pc); else pass++;
      #2 rst = 1;
      #1;
      total++; if (if_pc !== 30'd0) $display("FAIL async_rst_pc got %h exp 0", if_pc); else pass++;
      @(negedge clk);
      rst = 0; if_busy = 0; data_rdy = 1; insn = tag(30'd0);
      @(negedge clk);
      data_rdy = 0;
      total++; if (if_insn_pc !== 30'd0 || if_en !== 1'b1) $display("FAIL async_rst_fetch got en=%b pc=%h exp en=1 pc=0", if_en, if_insn_pc); else pass++;
      total++; if (if_pc !== 30'd1) $display("FAIL async_rst_next_pc got %h exp 1", if_pc); else pass++;
   endtask

   task automatic test_wrap;
      logic [29:0] p;
      do_reset;
      data_rdy = 1; id_stall = 1;
      for (int j = 0; j < 4; j++) begin
         p = 30'h3FFF_FFFE + 30'(j);
         insn = tag(p);
         total++; if (w_if_pc !== p) $display("FAIL wrap_pc[%0d] got %h exp %h", j, w_if_pc, p); else pass++;
         @(negedge clk);
      end
      total++; if (w_q_full !== 1'b1) $display("FAIL wrap_full got %b exp 1", w_q_full); else pass++;
      total++; if (w_if_pc !== 30'd2) $display("FAIL wrap_held_pc got %h exp 2", w_if_pc); else pass++;
      total++; if (w_if_insn_pc !== 30'h3FFF_FFFE) $display("FAIL wrap_head0 got %h exp 3ffffffe", w_if_insn_pc); else pass++;
      id_stall = 0; insn = tag(30'd2);
      @(negedge clk);
      id_stall = 1; data_rdy = 0;
      total++; if (w_q_full !== 1'b1) $display("FAIL pushpop_full got %b exp 1", w_q_full); else pass++;
      total++; if (w_if_insn_pc !== 30'h3FFF_FFFF) $display("FAIL pushpop_head got %h exp 3fffffff", w_if_insn_pc); else pass++;
      total++; if (w_if_pc !== 30'd3) $display("FAIL pushpop_pc got %h exp 3", w_if_pc); else pass++;
      @(negedge clk);
      total++; if (w_q_full !== 1'b1) $display("FAIL pushpop_hold_full got %b exp 1", w_q_full); else pass++;
      id_stall = 0;
      for (int h = 0; h < 4; h++) begin
         p = 30'h3FFF_FFFF + 30'(h);
         total++; if (w_if_insn_pc !== p) $display("FAIL wrap_drain_pc[%0d] got %h exp %h", h, w_if_insn_pc, p); else pass++;
         total++; if (w_if_insn !== tag(p)) $display("FAIL wrap_drain_insn[%0d] got %h exp %h", h, w_if_insn, tag(p)); else pass++;
         @(negedge clk);
      end
      total++; if (w_if_en !== 1'b0) $display("FAIL wrap_empty got %b exp 0", w_if_en); else pass++;
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall;
      test_miss;
      test_flush;
      test_redirect;
      test_async_reset;
      test_wrap;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
